// File: rtl/io_pkg.sv
// Shared constants and FSM encoding for the IO port arbiter.
package io_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 8;
    localparam logic [7:0]  IO_LIMIT = 8'h07;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StDone
    } io_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = en & (|req);
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares the 8-port memory-mapped IO block between the CPU (req0) and the debug port (req1),
// turning each accepted request into one timed setup + strobe access.
module io_port_arbiter #(
    parameter int unsigned          ADDR_W   = io_pkg::ADDR_W,
    parameter int unsigned          DATA_W   = io_pkg::DATA_W,
    parameter int unsigned          HOLD_CYC = 2,
    parameter logic [ADDR_W-1:0]    IO_LIMIT = ADDR_W'(io_pkg::IO_LIMIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_re,
    output logic              io_we,
    output logic [DATA_W-1:0] io_din,
    input  logic [DATA_W-1:0] io_dout,
    output logic              busy
);

    import io_pkg::*;

    localparam int unsigned CntW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    io_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              grant_q;
    logic              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic arb_grant;
    logic arb_any;
    logic addr_bad;
    logic hold_done;

    assign addr_bad  = addr_q > IO_LIMIT;
    assign hold_done = cnt_q == CntW'(HOLD_CYC - 1);

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .en         (state_q == StIdle),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_any) state_d = StSetup;
            end
            StSetup: begin
                cnt_d   = '0;
                // Out-of-range addresses skip the strobe and report err on completion.
                state_d = addr_bad ? StDone : StStrobe;
            end
            StStrobe: begin
                if (hold_done) state_d = StDone;
                else           cnt_d   = cnt_q + 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (state_q == StIdle && arb_any) begin
                grant_q <= arb_grant;
                we_q    <= arb_grant ? req1_we    : req0_we;
                addr_q  <= arb_grant ? req1_addr  : req0_addr;
                wdata_q <= arb_grant ? req1_wdata : req0_wdata;
            end
            if (state_q == StStrobe && hold_done && !we_q) rdata_q <= io_dout;
            if (state_q == StDone) last_grant_q <= grant_q;
        end
    end

    assign busy       = state_q != StIdle;
    assign io_addr    = addr_q;
    assign io_din     = wdata_q;
    assign io_re      = (state_q == StStrobe) & ~we_q;
    assign io_we      = (state_q == StStrobe) & we_q;
    assign req0_ready = (state_q == StDone) & ~grant_q;
    assign req1_ready = (state_q == StDone) & grant_q;
    assign err        = (state_q == StDone) & addr_bad;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Randomized scoreboard bench for io_port_arbiter with a rule-level reference model.
module tb_io_port_arbiter;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_we    = 2'b00;
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       req0_ready, req1_ready, err, io_re, io_we, busy;
    logic [7:0] rdata, io_addr, io_din, io_dout;
    logic [7:0] rom [8];

    // IO block model: reads are a fixed table, anything above 0x07 reads as 0xEE.
    assign io_dout = (io_addr < 8'd8) ? rom[io_addr[2:0]] : 8'hEE;

    always #5 clk = ~clk;

    io_port_arbiter #(.HOLD_CYC(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req_valid[0]),
        .req0_we    (req_we[0]),
        .req0_addr  (req_addr[0]),
        .req0_wdata (req_wdata[0]),
        .req0_ready (req0_ready),
        .req1_valid (req_valid[1]),
        .req1_we    (req_we[1]),
        .req1_addr  (req_addr[1]),
        .req1_wdata (req_wdata[1]),
        .req1_ready (req1_ready),
        .rdata      (rdata),
        .err        (err),
        .io_addr    (io_addr),
        .io_re      (io_re),
        .io_we      (io_we),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .busy       (busy)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t exp_q0[$];
    txn_t exp_q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor / reference model state
    int         cyc = 0;
    int         start_cyc = 0;
    int         exp_grant = -1;
    int         last_served = 1;
    logic [7:0] last_rdata = 8'h00;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_valid = 2'b00;
    int         st_cnt = 0;
    logic       st_we = 1'b0;
    logic [7:0] st_addr = 8'h00;
    logic [7:0] st_din = 8'h00;

    task automatic complete(input int id);
        txn_t t;
        logic bad;
        check("single_ready", {31'd0, req0_ready & req1_ready}, 0);
        check("grant_order", id, exp_grant);
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: req%0d pulsed ready with nothing outstanding", id);
        end else begin
            t   = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            bad = t.addr > 8'h07;
            check("err", {31'd0, err}, {31'd0, bad});
            check("latency", cyc - start_cyc, bad ? 1 : HOLD + 1);
            check("strobe_cycles", st_cnt, bad ? 0 : HOLD);
            if (!bad) begin
                check("strobe_kind", {31'd0, st_we}, {31'd0, t.we});
                check("strobe_addr", {24'd0, st_addr}, {24'd0, t.addr});
                if (t.we) check("strobe_din", {24'd0, st_din}, {24'd0, t.wdata});
                else      last_rdata = rom[t.addr[2:0]];
            end
            check("rdata", {24'd0, rdata}, {24'd0, last_rdata});
        end
        last_served = exp_grant;
        exp_grant   = -1;
        st_cnt      = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            st_cnt      = 0;
            exp_grant   = -1;
            last_served = 1;
            last_rdata  = 8'h00;
            prev_busy   = 1'b0;
            prev_valid  = 2'b00;
        end else begin
            if (busy && !prev_busy) begin
                start_cyc = cyc;
                check("grant_had_request", {31'd0, |prev_valid}, 1);
                if (prev_valid == 2'b11) exp_grant = 1 - last_served;
                else                     exp_grant = prev_valid[1] ? 1 : 0;
            end
            if (io_re || io_we) begin
                check("strobe_exclusive", {31'd0, io_re & io_we}, 0);
                if (st_cnt > 0) check("strobe_addr_stable", {24'd0, io_addr}, {24'd0, st_addr});
                st_cnt++;
                st_we   = io_we;
                st_addr = io_addr;
                st_din  = io_din;
            end
            if (req0_ready)      complete(0);
            else if (req1_ready) complete(1);
            else                 check("err_without_ready", {31'd0, err}, 0);
            prev_busy  = busy;
            prev_valid = req_valid;
        end
    end

    task automatic issue(input int id, input logic w, input logic [7:0] ad, input logic [7:0] d,
                         input bit drop_early);
        txn_t t;
        bit   got;
        t.we    = w;
        t.addr  = ad;
        t.wdata = d;
        @(posedge clk);
        #1;
        if (id == 0) exp_q0.push_back(t);
        else         exp_q1.push_back(t);
        req_we[id]    = w;
        req_addr[id]  = ad;
        req_wdata[id] = d;
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (drop_early && busy) req_valid[id] = 1'b0;
            if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
        end
        check($sformatf("ready_timeout_req%0d", id), {31'd0, got}, 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
        rom[7] = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_busy",   {31'd0, busy},       0);
        check("rst_io_re",  {31'd0, io_re},      0);
        check("rst_io_we",  {31'd0, io_we},      0);
        check("rst_ready0", {31'd0, req0_ready}, 0);
        check("rst_ready1", {31'd0, req1_ready}, 0);
        check("rst_err",    {31'd0, err},        0);
        check("rst_rdata",  {24'd0, rdata},      0);
        check("rst_io_addr", {24'd0, io_addr},   0);
        check("rst_io_din", {24'd0, io_din},     0);

        // Tie straight after reset, then continuous contention
        fork
            issue(0, 1'b1, 8'h02, 8'h11, 1'b0);
            issue(1, 1'b0, 8'h05, 8'h00, 1'b0);
        join
        fork
            for (int i = 0; i < 3; i++) issue(0, 1'b1, 8'(i), 8'(8'h40 + i), 1'b0);
            for (int i = 0; i < 3; i++) issue(1, 1'b0, 8'(i + 4), 8'h00, 1'b0);
        join

        issue(0, 1'b1, 8'h01, 8'hA5, 1'b0);
        issue(1, 1'b0, 8'h07, 8'h00, 1'b0);
        issue(0, 1'b0, 8'h08, 8'h00, 1'b0);

        issue(0, 1'b1, 8'h04, 8'h77, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("no_second_access", {31'd0, busy}, 0);
        end

        // Reset in the second strobe cycle of a write
        @(posedge clk);
        #1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h03;
        req_wdata[0] = 8'h5A;
        req_valid[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            if (io_we) n++;
        end
        check("rst_reached_strobe2", n, 2);
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("midrst_io_we", {31'd0, io_we}, 0);
        check("midrst_busy",  {31'd0, busy},  0);
        check("midrst_ready", {31'd0, req0_ready | req1_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 1'b1, 8'h03, 8'h5A, 1'b0);

        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                issue(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 8'($urandom), 1'b0);
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                issue(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 8'($urandom), 1'b0);
            end
        join

        repeat (10) @(negedge clk);
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        check("final_idle", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
